// File: rtl/regfile_wr_sched.sv
// regfile_wr_sched
//   Write-port scheduler for the dual-write register file. After reset it
//   clears every register, two per cycle, through both write ports. It then
//   shares the two write ports round-robin among NUM_REQ write-back
//   requesters and never puts the same address on both ports in one cycle.
//
// Optional feature macro: REGFILE_R31_PROTECT_EN
//   When defined, a granted write to address NUM_REGS-1 is acknowledged but
//   not issued. Its port stays idle and drop_err pulses for one cycle. The
//   clear sequence still writes that register. When undefined, that address
//   is scheduled like any other and drop_err is constant 0.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req_valid/addr/data per-requester write requests (flat vectors)
//   req_ready           combinational grant; transfer on valid & ready
//   wr_en0/addr0/data0  registered write port 0
//   wr_en1/addr1/data1  registered write port 1
//   init_busy           clear sequence in progress
//   drop_err            one-cycle pulse for a protected write that was dropped
//
// State | meaning
//   S_CLEAR | writing zeros to register pairs (2k, 2k+1); no grants
//   S_RUN   | round-robin arbitration onto the two write ports
module regfile_wr_sched #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 40,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [ADDR_W-1:0]         wr_addr0,
    output logic [DATA_W-1:0]         wr_data0,
    output logic                      wr_en0,
    output logic [ADDR_W-1:0]         wr_addr1,
    output logic [DATA_W-1:0]         wr_data1,
    output logic                      wr_en1,
    output logic                      init_busy,
    output logic                      drop_err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PAIRS = NUM_REGS / 2;
    localparam int CNT_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    clr_cnt_q;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic                wr_en0_q, wr_en1_q, init_busy_q, drop_err_q;
    logic [ADDR_W-1:0]   wr_addr0_q, wr_addr1_q;
    logic [DATA_W-1:0]   wr_data0_q, wr_data1_q;

    logic [ADDR_W-1:0]   addr_a [NUM_REQ];
    logic [DATA_W-1:0]   data_a [NUM_REQ];

    logic                g0_vld, g1_vld;
    logic [IDX_W-1:0]    g0_idx, g1_idx;
    logic [ADDR_W-1:0]   g0_addr, g1_addr;
    logic [DATA_W-1:0]   g0_data, g1_data;
    logic                drop0, drop1;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_a[i] = req_addr[i*ADDR_W +: ADDR_W];
        assign data_a[i] = req_data[i*DATA_W +: DATA_W];
    end

    // Scan from ptr; the first valid requester takes port 0, the next valid
    // one with a different address takes port 1. Same-address requesters
    // are simply passed over and keep waiting.
    always_comb begin : arb
        logic [IDX_W-1:0] sel;
        sel     = '0;
        g0_vld  = 1'b0;
        g0_idx  = '0;
        g0_addr = '0;
        g0_data = '0;
        g1_vld  = 1'b0;
        g1_idx  = '0;
        g1_addr = '0;
        g1_data = '0;
        for (int o = 0; o < NUM_REQ; o++) begin
            sel = IDX_W'((int'(ptr_q) + o) % NUM_REQ);
            if (req_valid[sel]) begin
                if (!g0_vld) begin
                    g0_vld  = 1'b1;
                    g0_idx  = sel;
                    g0_addr = addr_a[sel];
                    g0_data = data_a[sel];
                end else if (!g1_vld && (addr_a[sel] != g0_addr)) begin
                    g1_vld  = 1'b1;
                    g1_idx  = sel;
                    g1_addr = addr_a[sel];
                    g1_data = data_a[sel];
                end
            end
        end
    end

`ifdef REGFILE_R31_PROTECT_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
    assign drop0 = g0_vld && (g0_addr == LAST_ADDR);
    assign drop1 = g1_vld && (g1_addr == LAST_ADDR);
`else
    assign drop0 = 1'b0;
    assign drop1 = 1'b0;
`endif

    // Port 1's winner, when present, is always later in the rotation than
    // port 0's, so it decides the next starting point.
    always_comb begin
        ptr_d = ptr_q;
        if (g1_vld) begin
            ptr_d = IDX_W'((int'(g1_idx) + 1) % NUM_REQ);
        end else if (g0_vld) begin
            ptr_d = IDX_W'((int'(g0_idx) + 1) % NUM_REQ);
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == S_RUN) begin
            if (g0_vld) req_ready[g0_idx] = 1'b1;
            if (g1_vld) req_ready[g1_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_CLEAR;
            clr_cnt_q   <= '0;
            ptr_q       <= '0;
            wr_en0_q    <= 1'b0;
            wr_en1_q    <= 1'b0;
            wr_addr0_q  <= '0;
            wr_addr1_q  <= '0;
            wr_data0_q  <= '0;
            wr_data1_q  <= '0;
            init_busy_q <= 1'b1;
            drop_err_q  <= 1'b0;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    wr_en0_q   <= 1'b1;
                    wr_en1_q   <= 1'b1;
                    wr_addr0_q <= ADDR_W'({clr_cnt_q, 1'b0});
                    wr_addr1_q <= ADDR_W'({clr_cnt_q, 1'b1});
                    wr_data0_q <= '0;
                    wr_data1_q <= '0;
                    drop_err_q <= 1'b0;
                    if (clr_cnt_q == CNT_W'(PAIRS - 1)) begin
                        state_q     <= S_RUN;
                        clr_cnt_q   <= '0;
                        init_busy_q <= 1'b0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    wr_en0_q   <= g0_vld && !drop0;
                    wr_en1_q   <= g1_vld && !drop1;
                    wr_addr0_q <= g0_addr;
                    wr_addr1_q <= g1_addr;
                    wr_data0_q <= g0_data;
                    wr_data1_q <= g1_data;
                    drop_err_q <= drop0 || drop1;
                    ptr_q      <= ptr_d;
                end
                default: begin
                    state_q <= S_CLEAR;
                end
            endcase
        end
    end

    assign wr_en0    = wr_en0_q;
    assign wr_en1    = wr_en1_q;
    assign wr_addr0  = wr_addr0_q;
    assign wr_addr1  = wr_addr1_q;
    assign wr_data0  = wr_data0_q;
    assign wr_data1  = wr_data1_q;
    assign init_busy = init_busy_q;
    assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_regfile_wr_sched.sv
// tb_regfile_wr_sched
//   Drives directed and random write-back traffic into regfile_wr_sched and
//   compares every cycle against a behavioural model of the scheduler:
//   clear-pair sequence, round-robin grants, port outputs, busy and drop flags.
//   Build with REGFILE_R31_PROTECT_EN to check the protected-address variant.
module tb_regfile_wr_sched;

    localparam int N     = 4;
    localparam int AW    = 5;
    localparam int DW    = 40;
    localparam int NREGS = 32;
    localparam int PAIRS = NREGS / 2;
`ifdef REGFILE_R31_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic            clk, rst;
    logic [N-1:0]    req_valid, req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [AW-1:0]   wr_addr0, wr_addr1;
    logic [DW-1:0]   wr_data0, wr_data1;
    logic            wr_en0, wr_en1, init_busy, drop_err;

    int n_vec = 0;
    int n_err = 0;

    // Model state: clearing or running, next pair to clear, rotation start.
    bit           m_run;
    int           m_pair;
    int           m_ptr;
    logic [N-1:0] last_rdy;

    regfile_wr_sched #(
        .NUM_REQ (N),
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .NUM_REGS(NREGS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_addr (req_addr),
        .req_data (req_data),
        .req_ready(req_ready),
        .wr_addr0 (wr_addr0),
        .wr_data0 (wr_data0),
        .wr_en0   (wr_en0),
        .wr_addr1 (wr_addr1),
        .wr_data1 (wr_data1),
        .wr_en1   (wr_en1),
        .init_busy(init_busy),
        .drop_err (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input int i);
        return req_addr[i*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] data_of(input int i);
        return req_data[i*DW +: DW];
    endfunction

    function automatic bit prot(input logic [AW-1:0] a);
        return PROT && (a == AW'(NREGS - 1));
    endfunction

    // Valid requesters listed in rotation order from the pointer; port 0 is
    // the head of the list, port 1 the first later entry with another address.
    function automatic void ref_arb(output int g0, output int g1);
        int q[$];
        g0 = -1;
        g1 = -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (req_valid[i]) q.push_back(i);
        end
        if (q.size() > 0) g0 = q[0];
        for (int j = 1; j < q.size(); j++) begin
            if (g1 < 0 && addr_of(q[j]) != addr_of(g0)) g1 = q[j];
        end
    endfunction

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]        = 1'b1;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic rand_req(input int i);
        logic [AW-1:0] a;
        a = ($urandom_range(0, 3) == 0) ? AW'(NREGS - 1) : AW'($urandom_range(0, 7));
        set_req(i, a, DW'({$urandom, $urandom}));
    endtask

    // Called at a falling edge with inputs already applied; checks grants
    // before the rising edge and the registered ports after it.
    task automatic cycle();
        int            g0, g1;
        bit            r;
        logic [N-1:0]  erdy;
        logic          e_en0, e_en1, e_drop, chk0, chk1;
        logic [AW-1:0] e_a0, e_a1;
        logic [DW-1:0] e_d0, e_d1;
        #1;
        ref_arb(g0, g1);
        erdy = '0;
        if (m_run) begin
            if (g0 >= 0) erdy[g0] = 1'b1;
            if (g1 >= 0) erdy[g1] = 1'b1;
        end
        check_val("req_ready", req_ready, erdy);
        last_rdy = erdy;
        r = rst;
        e_a0 = '0; e_a1 = '0; e_d0 = '0; e_d1 = '0;
        e_en0 = 1'b0; e_en1 = 1'b0; e_drop = 1'b0;
        if (r) begin
            m_run = 1'b0; m_pair = 0; m_ptr = 0;
        end else if (!m_run) begin
            e_en0 = 1'b1; e_en1 = 1'b1;
            e_a0  = AW'(2 * m_pair);
            e_a1  = AW'(2 * m_pair + 1);
            if (m_pair == PAIRS - 1) begin
                m_run = 1'b1; m_pair = 0;
            end else begin
                m_pair++;
            end
        end else begin
            if (g0 >= 0) begin
                e_en0  = !prot(addr_of(g0));
                e_a0   = addr_of(g0);
                e_d0   = data_of(g0);
                e_drop = prot(addr_of(g0));
            end
            if (g1 >= 0) begin
                e_en1  = !prot(addr_of(g1));
                e_a1   = addr_of(g1);
                e_d1   = data_of(g1);
                e_drop = e_drop || prot(addr_of(g1));
            end
            if (g1 >= 0) m_ptr = (g1 + 1) % N;
            else if (g0 >= 0) m_ptr = (g0 + 1) % N;
        end
        chk0 = e_en0 || r;
        chk1 = e_en1 || r;
        @(posedge clk);
        #1;
        check_val("wr_en0", wr_en0, e_en0);
        check_val("wr_en1", wr_en1, e_en1);
        check_val("init_busy", init_busy, !m_run);
        check_val("drop_err", drop_err, e_drop);
        if (chk0) begin
            check_val("wr_addr0", wr_addr0, e_a0);
            check_val("wr_data0", wr_data0, e_d0);
        end
        if (chk1) begin
            check_val("wr_addr1", wr_addr1, e_a1);
            check_val("wr_data1", wr_data1, e_d1);
        end
        @(negedge clk);
    endtask

    // Granted requesters either retire or (random mode) post a fresh write;
    // ungranted ones hold their request unchanged.
    task automatic upd_reqs(input bit rnd);
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && last_rdy[i]) begin
                if (rnd && $urandom_range(0, 1) == 1) rand_req(i);
                else req_valid[i] = 1'b0;
            end else if (!req_valid[i] && rnd && $urandom_range(0, 2) == 0) begin
                rand_req(i);
            end
        end
    endtask

    task automatic run(input int n, input bit rnd);
        for (int k = 0; k < n; k++) begin
            cycle();
            upd_reqs(rnd);
        end
    endtask

    initial begin
        m_run = 1'b0; m_pair = 0; m_ptr = 0; last_rdy = '0;
        rst = 1'b1;
        req_valid = '0; req_addr = '0; req_data = '0;
        for (int i = 0; i < N; i++) set_req(i, AW'(10 + i), DW'({$urandom, $urandom}));
        @(negedge clk);
        @(negedge clk);
        run(2, 1'b0);

        // Clear sequence with every requester already waiting.
        rst = 1'b0;
        run(PAIRS, 1'b0);
        run(3, 1'b0);

        // Single requester on port 0.
        set_req(0, AW'(5), 40'h12_3456_789A);
        run(2, 1'b0);
        // Bring the rotation back to requester 0.
        set_req(3, AW'(9), DW'({$urandom, $urandom}));
        run(2, 1'b0);

        // Four distinct addresses: pairs (0,1) then (2,3).
        for (int i = 0; i < N; i++) set_req(i, AW'(1 + i), DW'({$urandom, $urandom}));
        run(3, 1'b0);

        // Address conflict between requesters 0 and 1.
        set_req(0, AW'(7), DW'({$urandom, $urandom}));
        set_req(1, AW'(7), DW'({$urandom, $urandom}));
        run(3, 1'b0);

        // Top register through requester 2.
        set_req(2, AW'(NREGS - 1), DW'({$urandom, $urandom}));
        run(2, 1'b0);

        // Random traffic.
        run(300, 1'b1);

        // One-cycle reset during traffic, then a reset partway through clear.
        rst = 1'b1;
        run(1, 1'b1);
        rst = 1'b0;
        run(5, 1'b1);
        rst = 1'b1;
        run(1, 1'b1);
        rst = 1'b0;
        run(PAIRS + 300, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_wr_sched.md
Name: regfile_wr_sched

Overview:
Write-port scheduler for the 32 x 40-bit dual-write register file. After reset it clears every register through both write ports. It then shares the two write ports among NUM_REQ write-back requesters using round-robin, one write per port per cycle. It guarantees the two ports never target the same address in one cycle.

Parameters:
NUM_REQ, 4, number of write-back requesters (2..8)
DATA_W, 40, register data width
ADDR_W, 5, register address width
NUM_REGS, 32, registers cleared after reset (even, <= 2**ADDR_W)

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  requester i has a write pending
req_addr  in  NUM_REQ*ADDR_W  flat; requester i at [i*ADDR_W +: ADDR_W]
req_data  in  NUM_REQ*DATA_W  flat; requester i at [i*DATA_W +: DATA_W]
req_ready  out  NUM_REQ  combinational grant; a transfer occurs when valid & ready
wr_addr0/wr_data0/wr_en0  out  ADDR_W/DATA_W/1  registered write port 0
wr_addr1/wr_data1/wr_en1  out  ADDR_W/DATA_W/1  registered write port 1
init_busy  out  1  clear sequence in progress
drop_err  out  1  dropped-write pulse; see Optional Feature

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, ports named clk and rst.
- Reset values: wr_en0 = wr_en1 = 0; wr_addr*, wr_data* = 0; drop_err = 0; init_busy = 1; state = CLEAR; clear counter = 0; round-robin ptr = 0.
- FSM CLEAR:
  - Each cycle, register wr_en0 = wr_en1 = 1, wr_addr0 = 2k, wr_addr1 = 2k+1, data = 0, for k = 0 .. NUM_REGS/2-1.
  - Pair k is on the ports during cycle k+1 after rst deasserts.
  - On the edge that registers the final pair, state moves to RUN.
  - req_ready = 0 throughout CLEAR; req_valid is ignored.
- init_busy = (state == CLEAR), registered. It is low from the cycle the final pair (NUM_REGS-2, NUM_REGS-1) is on the ports, and requests are accepted from that cycle.
- FSM RUN, arbitration in one cycle:
  - Port-0 winner: the first valid requester scanning ptr, ptr+1, ... mod NUM_REQ.
  - Port-1 winner: the first valid requester after the port-0 winner in the same rotation whose address differs from the port-0 winner's address. Requesters with an equal address are skipped and stay pending.
  - req_ready is 1 only for the winners. Non-winners must hold valid, addr and data stable.
- Latency: an accepted request appears on its port in the next cycle (wr_en = 1). A port with no winner drives wr_en = 0; addr and data are don't-care.
- Pointer: ptr <= (index of last granted requester + 1) mod NUM_REQ. ptr is unchanged if nothing is granted.
- Ordering: at most one grant per requester per cycle. One requester's writes reach the file in acceptance order.
- Reset mid-operation: in the cycle after rst is sampled high, wr_en0 and wr_en1 are 0. An accepted-but-unissued write is discarded. The clear sequence restarts from pair (0,1) after release.
- No other state; the block never stalls in RUN except for lack of valid requests.

Optional Feature:
- Macro REGFILE_R31_PROTECT_EN.
- Defined: a winner whose address is NUM_REGS-1 is acknowledged and consumes its port slot.
  - Its port drives wr_en = 0 the next cycle, and drop_err = 1 for that one cycle.
  - The clear sequence still writes NUM_REGS-1.
- Undefined: that address is scheduled like any other, and drop_err is constant 0.

Test Plan:
1. Release rst with all req_valid = 1 -> 16 cycles of pairs (0,1) .. (30,31), data 0, both wr_en = 1. req_ready = 0 until init_busy falls in cycle 16.
2. RUN, only req0 valid, addr 5, data 40'h12_3456_789A -> req_ready = 4'b0001 that cycle. Next cycle wr_en0 = 1, wr_addr0 = 5, wr_data0 = 40'h12_3456_789A, wr_en1 = 0.
3. ptr = 0, all four valid with addrs 1, 2, 3, 4:
   - Cycle A: grants 0 -> port0, 1 -> port1, ptr = 2.
   - Cycle A+1: grants 2 and 3, ptr = 0.
   - Writes to 1/2 then 3/4 appear one cycle after each grant.
4. ptr = 0, req0 and req1 both addr 7 -> cycle A grants only req0 (port0), ptr = 1. Cycle A+1 grants req1 on port0, with wr_en1 = 0 in both write cycles.
5. rst pulsed for 1 cycle during RUN traffic -> next cycle wr_en0 = wr_en1 = 0 and init_busy = 1. After release the clear restarts at (0,1).
6. req2 valid, addr 31:
   - With REGFILE_R31_PROTECT_EN: req_ready[2] = 1, next cycle wr_en0 = 0 and drop_err = 1.
   - Without: wr_en0 = 1, wr_addr0 = 31, drop_err = 0.
